wb_sram_ctrl: RTL and testbench

WB_SRAM_CTRL -- requirements
Module: wb_sram_ctrl

---
 rtl/wb_sram_ctrl.sv | 171 +++++++++++++++++
 tb/tb_wb_sram_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : wb_sram_ctrl
//  Purpose  : Wishbone (pipelined-style stall/ack) slave that performs single
//             asynchronous SRAM read/write accesses with a fixed strobe width.
//             One request is accepted in IDLE; requests seen while busy are
//             dropped (the master sees stall=1 and must retry).
//  Ports    : wb_clock_i / wb_reset_n_i   clock, async active-low reset
//             wb_addr_i, wb_din_i, wb_we_i, wb_cycle_i, wb_strobe_i
//                                         bus request from the arbiter
//             wb_dout_o, wb_stall_o, wb_ack_o
//                                         read data and handshake to arbiter
//             ram_addr_o, ram_data_o, ram_data_oe_o, ram_data_i
//                                         SRAM address and split data bus
//             ram_ce_n_o, ram_oe_n_o, ram_we_n_o
//                                         active-low SRAM strobes
//  Revision : 1.0  initial release
// ============================================================================
module wb_sram_ctrl #(
    parameter int ADDR_WIDTH    = 17,
    parameter int DATA_WIDTH    = 8,
    parameter int WAIT_CYCLES   = 2,
    parameter int WB_ADDR_WIDTH = 20
) (
    input  logic                     wb_clock_i,
    input  logic                     wb_reset_n_i,
    input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [DATA_WIDTH-1:0]    wb_din_i,
    output logic [DATA_WIDTH-1:0]    wb_dout_o,
    input  logic                     wb_we_i,
    input  logic                     wb_cycle_i,
    input  logic                     wb_strobe_i,
    output logic                     wb_stall_o,
    output logic                     wb_ack_o,
    output logic [ADDR_WIDTH-1:0]    ram_addr_o,
    input  logic [DATA_WIDTH-1:0]    ram_data_i,
    output logic [DATA_WIDTH-1:0]    ram_data_o,
    output logic                     ram_data_oe_o,
    output logic                     ram_ce_n_o,
    output logic                     ram_oe_n_o,
    output logic                     ram_we_n_o
);

    // ------------------------------------------------------------------------
    // Elaboration checks
    // ------------------------------------------------------------------------
    if (WAIT_CYCLES < 1) begin : g_wait_check
        $error("wb_sram_ctrl: WAIT_CYCLES must be >= 1");
    end
    if (WB_ADDR_WIDTH < ADDR_WIDTH) begin : g_addr_check
        $error("wb_sram_ctrl: WB_ADDR_WIDTH must be >= ADDR_WIDTH");
    end

    // Upper bus address bits select nothing in this SRAM; fold them into a
    // sink so they are visibly consumed.
    if (WB_ADDR_WIDTH > ADDR_WIDTH) begin : g_upper_addr
        logic unused_upper_addr;
        assign unused_upper_addr = ^wb_addr_i[WB_ADDR_WIDTH-1:ADDR_WIDTH];
    end

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int              CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_HOLD   = 2'd2,
        S_ACK    = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q,   cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
    logic [DATA_WIDTH-1:0]   data_q,  data_d;
    logic                    we_q,    we_d;
    logic [DATA_WIDTH-1:0]   dout_q,  dout_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = we_q;
        dout_d  = dout_q;

        case (state_q)
            S_IDLE: begin
                if (wb_cycle_i && wb_strobe_i) begin
                    addr_d  = wb_addr_i[ADDR_WIDTH-1:0];
                    data_d  = wb_din_i;
                    we_d    = wb_we_i;
                    cnt_d   = CNT_LOAD;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    if (we_q) begin
                        state_d = S_HOLD;
                    end else begin
                        // Sample SRAM data on the last edge of the strobe
                        dout_d  = ram_data_i;
                        state_d = S_ACK;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_HOLD: begin
                state_d = S_ACK;
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clock_i or negedge wb_reset_n_i) begin
        if (!wb_reset_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            dout_q  <= dout_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: decoded from registered state only, so an asynchronous reset
    // releases the SRAM strobes and data bus immediately.
    // ------------------------------------------------------------------------
    logic in_access;
    logic in_hold;

    assign in_access = (state_q == S_ACCESS);
    assign in_hold   = (state_q == S_HOLD);

    assign wb_stall_o    = (state_q != S_IDLE);
    // Ack is qualified by the live cycle signal so an abandoned cycle is not
    // acknowledged.
    assign wb_ack_o      = (state_q == S_ACK) && wb_cycle_i;
    assign wb_dout_o     = dout_q;

    assign ram_addr_o    = addr_q;
    assign ram_data_o    = data_q;
    assign ram_ce_n_o    = ~(in_access | in_hold);
    assign ram_oe_n_o    = ~(in_access & ~we_q);
    assign ram_we_n_o    = ~(in_access & we_q);
    // HOLD keeps the data driven one cycle past the WE rising edge.
    assign ram_data_oe_o = (in_access | in_hold) & we_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_sram_ctrl
//  Purpose  : Self-checking bench for wb_sram_ctrl. A behavioural SRAM sits on
//             the pins; a byte-array reference memory predicts read data and
//             the transfer timing is predicted from WAIT_CYCLES.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_sram_ctrl;

    localparam int AW   = 17;
    localparam int DW   = 8;
    localparam int WAIT = 2;
    localparam int WBAW = 20;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [WBAW-1:0] wb_addr_i;
    logic [DW-1:0]   wb_din_i;
    logic [DW-1:0]   wb_dout_o;
    logic            wb_we_i;
    logic            wb_cycle_i;
    logic            wb_strobe_i;
    logic            wb_stall_o;
    logic            wb_ack_o;
    logic [AW-1:0]   ram_addr_o;
    logic [DW-1:0]   ram_data_i;
    logic [DW-1:0]   ram_data_o;
    logic            ram_data_oe_o;
    logic            ram_ce_n_o;
    logic            ram_oe_n_o;
    logic            ram_we_n_o;

    always #5 clk = ~clk;

    wb_sram_ctrl #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .WAIT_CYCLES   (WAIT),
        .WB_ADDR_WIDTH (WBAW)
    ) u_dut (
        .wb_clock_i    (clk),
        .wb_reset_n_i  (rst_n),
        .wb_addr_i     (wb_addr_i),
        .wb_din_i      (wb_din_i),
        .wb_dout_o     (wb_dout_o),
        .wb_we_i       (wb_we_i),
        .wb_cycle_i    (wb_cycle_i),
        .wb_strobe_i   (wb_strobe_i),
        .wb_stall_o    (wb_stall_o),
        .wb_ack_o      (wb_ack_o),
        .ram_addr_o    (ram_addr_o),
        .ram_data_i    (ram_data_i),
        .ram_data_o    (ram_data_o),
        .ram_data_oe_o (ram_data_oe_o),
        .ram_ce_n_o    (ram_ce_n_o),
        .ram_oe_n_o    (ram_oe_n_o),
        .ram_we_n_o    (ram_we_n_o)
    );

    // ------------------------------------------------------------------------
    // Behavioural SRAM on the pins
    // ------------------------------------------------------------------------
    logic [DW-1:0] sram [0:(1<<AW)-1];

    initial begin
        for (int i = 0; i < (1 << AW); i++) sram[i] = '0;
    end

    always @(posedge clk) begin
        if (!ram_ce_n_o && !ram_we_n_o) sram[ram_addr_o] <= ram_data_o;
    end

    // Off-bus value is a recognisable junk pattern
    assign ram_data_i = (!ram_ce_n_o && !ram_oe_n_o) ? sram[ram_addr_o] : 8'hEE;

    // ------------------------------------------------------------------------
    // Reference model and checking
    // ------------------------------------------------------------------------
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] exp_dout;
    int            n_total = 0;
    int            n_bad   = 0;

    function automatic logic [DW-1:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One complete transfer, started at a negedge. The observation window
    // covers every cycle until the controller should be idle again.
    task automatic xfer(input bit we, input logic [WBAW-1:0] a, input logic [DW-1:0] d,
                        input bit hold, input bit drop);
        int            ack_at;
        int            first_ack;
        int            n_ack;
        int            n_we;
        int            n_oe;
        int            n_ce;
        int            n_busy;
        bit            stable;
        bit            viol;
        logic          last_stall;
        logic [AW-1:0] ta;

        ta        = a[AW-1:0];
        ack_at    = we ? WAIT + 1 : WAIT;
        first_ack = -1;
        n_ack = 0; n_we = 0; n_oe = 0; n_ce = 0; n_busy = 0;
        stable = 1'b1; viol = 1'b0; last_stall = 1'b1;

        wb_cycle_i  = 1'b1;
        wb_strobe_i = 1'b1;
        wb_we_i     = we;
        wb_addr_i   = a;
        wb_din_i    = d;
        @(posedge clk);  // E0
        #1;
        if (!hold) wb_strobe_i = 1'b0;
        // Request fields must have been latched; disturb them
        wb_addr_i = WBAW'($urandom);
        wb_din_i  = DW'($urandom);
        wb_we_i   = 1'($urandom);

        for (int j = 0; j <= ack_at + 1; j++) begin
            @(negedge clk);
            if (wb_ack_o) begin
                n_ack++;
                if (first_ack < 0) first_ack = j;
            end
            if (!ram_we_n_o) n_we++;
            if (!ram_oe_n_o) n_oe++;
            if (!ram_ce_n_o) n_ce++;
            if (wb_stall_o && j <= ack_at) n_busy++;
            if (!ram_we_n_o && !ram_oe_n_o) viol = 1'b1;
            if (ram_data_oe_o && !ram_oe_n_o) viol = 1'b1;
            if (!ram_ce_n_o && ram_addr_o !== ta) stable = 1'b0;
            if (ram_data_oe_o && ram_data_o !== d) stable = 1'b0;
            last_stall = wb_stall_o;
            if (drop && j == 0) wb_cycle_i = 1'b0;
            if (j == ack_at) wb_strobe_i = 1'b0;
        end

        chk(we ? "wr_ack_pos" : "rd_ack_pos", 32'(first_ack), drop ? 32'hFFFF_FFFF : 32'(ack_at));
        chk("ack_count", 32'(n_ack), drop ? 32'd0 : 32'd1);
        chk("we_low_cycles", 32'(n_we), we ? 32'(WAIT) : 32'd0);
        chk("oe_low_cycles", 32'(n_oe), we ? 32'd0 : 32'(WAIT));
        chk("ce_low_cycles", 32'(n_ce), we ? 32'(WAIT + 1) : 32'(WAIT));
        chk("busy_cycles", 32'(n_busy), 32'(ack_at + 1));
        chk("idle_after", {31'd0, last_stall}, 32'd0);
        chk("addr_data_stable", {31'd0, stable}, 32'd1);
        chk("strobe_rules", {31'd0, viol}, 32'd0);

        if (we) ref_mem[int'(ta)] = d;
        else    exp_dout = ref_rd(int'(ta));
        chk("dout", {24'd0, wb_dout_o}, {24'd0, exp_dout});

        wb_cycle_i  = 1'b0;
        wb_strobe_i = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        logic [WBAW-1:0] ra;
        logic [DW-1:0]   rd;
        bit              rwe;
        int              lo;

        rst_n       = 1'b0;
        wb_addr_i   = '0;
        wb_din_i    = '0;
        wb_we_i     = 1'b0;
        wb_cycle_i  = 1'b0;
        wb_strobe_i = 1'b0;
        exp_dout    = '0;

        #2;
        chk("rst_stall", {31'd0, wb_stall_o}, 32'd0);
        chk("rst_ack", {31'd0, wb_ack_o}, 32'd0);
        chk("rst_strobes", {29'd0, ram_ce_n_o, ram_oe_n_o, ram_we_n_o}, 32'h7);
        chk("rst_data_oe", {31'd0, ram_data_oe_o}, 32'd0);
        chk("rst_addr", {15'd0, ram_addr_o}, 32'd0);
        chk("rst_wdata", {24'd0, ram_data_o}, 32'd0);
        chk("rst_dout", {24'd0, wb_dout_o}, 32'd0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed: write then read back, write elsewhere keeps dout
        xfer(1'b1, 20'h00123, 8'hA5, 1'b0, 1'b0);
        chk("sram_0123", {24'd0, sram[17'h00123]}, 32'h0000_00A5);
        xfer(1'b0, 20'h00123, 8'h00, 1'b0, 1'b0);
        xfer(1'b1, 20'h00200, 8'h5A, 1'b0, 1'b0);
        chk("dout_after_wr", {24'd0, wb_dout_o}, 32'h0000_00A5);

        // Address truncation with strobe held through the read
        xfer(1'b0, 20'hE0123, 8'h00, 1'b1, 1'b0);

        // Cycle dropped mid-write: SRAM still written, no ack
        xfer(1'b1, 20'h00300, 8'h3C, 1'b0, 1'b1);
        chk("sram_dropped_wr", {24'd0, sram[17'h00300]}, 32'h0000_003C);
        xfer(1'b0, 20'h00300, 8'h00, 1'b0, 1'b0);

        // Reset during ACCESS of a write
        wb_cycle_i  = 1'b1;
        wb_strobe_i = 1'b1;
        wb_we_i     = 1'b1;
        wb_addr_i   = 20'h00400;
        wb_din_i    = 8'h77;
        @(posedge clk);
        #1 wb_strobe_i = 1'b0;
        @(negedge clk);
        chk("mid_access_we", {31'd0, ram_we_n_o}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_strobes", {29'd0, ram_ce_n_o, ram_oe_n_o, ram_we_n_o}, 32'h7);
        chk("arst_data_oe", {31'd0, ram_data_oe_o}, 32'd0);
        chk("arst_ack", {31'd0, wb_ack_o}, 32'd0);
        chk("arst_stall", {31'd0, wb_stall_o}, 32'd0);
        exp_dout = '0;
        chk("arst_dout", {24'd0, wb_dout_o}, 32'd0);
        wb_cycle_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xfer(1'b0, 20'h00123, 8'h00, 1'b0, 1'b0);

        // Randomised traffic over a small address pool so reads hit writes
        for (int n = 0; n < 60; n++) begin
            lo  = 32'h100 + 32'($urandom_range(0, 7)) * 32'h111;
            ra  = (WBAW'($urandom) & 20'hE0000) | WBAW'(lo);
            rd  = DW'($urandom);
            rwe = 1'($urandom);
            xfer(rwe, ra, rd, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
